// File: rtl/password_checker.sv
// password_checker: read side of the serial password lock.
// Digits arrive one per digit_valid strobe. Each one is compared in the same
// cycle against the stored digit at mem_address. Mismatches accumulate, and
// a single RESULT cycle then reports pass or fail.
// Optional feature macro: PWD_LOCKOUT_EN. It adds a consecutive-fail counter
// and a timed LOCKED state, and exposes the MAX_FAILS / LOCK_CYCLES parameters.
module password_checker #(
    parameter int DIGITS      = 4,
    parameter int DIGIT_W     = 4,
    parameter int ADDR_W      = $clog2(DIGITS)
`ifdef PWD_LOCKOUT_EN
    ,
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 16
`endif
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               digit_valid,
    input  logic [DIGIT_W-1:0] digit_in,
    input  logic               clear,
    input  logic               relock,
    output logic [ADDR_W-1:0]  mem_address,
    input  logic [DIGIT_W-1:0] mem_data,
    output logic [ADDR_W:0]    digit_count,
    output logic               pass_pulse,
    output logic               fail_pulse,
    output logic               unlocked,
    output logic               locked_out
);

    typedef enum logic [1:0] {
        IDLE,
        ENTER,
        RESULT
`ifdef PWD_LOCKOUT_EN
        ,
        LOCKED
`endif
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(DIGITS - 1);
    localparam logic [ADDR_W-1:0] INDEX_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W + 1)'(1);

`ifdef PWD_LOCKOUT_EN
    localparam int FAIL_W  = $clog2(MAX_FAILS + 1);
    localparam int TIMER_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [FAIL_W-1:0]  LAST_FAIL  = FAIL_W'(MAX_FAILS - 1);
    localparam logic [FAIL_W-1:0]  FAIL_ONE   = FAIL_W'(1);
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(LOCK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

    logic [FAIL_W-1:0]  r_failCount;
    logic [FAIL_W-1:0]  w_failCountNext;
    logic [TIMER_W-1:0] r_lockTimer;
    logic [TIMER_W-1:0] w_lockTimerNext;
`endif

    state_t              r_state;
    state_t              w_stateNext;
    logic [ADDR_W-1:0]   r_index;
    logic [ADDR_W-1:0]   w_indexNext;
    logic                r_mismatch;
    logic                w_mismatchNext;
    logic [ADDR_W:0]     r_count;
    logic [ADDR_W:0]     w_countNext;
    logic                r_unlocked;
    logic                w_unlockedNext;

    // State and datapath registers. The synchronous reset returns everything to idle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_index     <= '0;
            r_mismatch  <= 1'b0;
            r_count     <= '0;
            r_unlocked  <= 1'b0;
`ifdef PWD_LOCKOUT_EN
            r_failCount <= '0;
            r_lockTimer <= '0;
`endif
        end else begin
            r_state     <= w_stateNext;
            r_index     <= w_indexNext;
            r_mismatch  <= w_mismatchNext;
            r_count     <= w_countNext;
            r_unlocked  <= w_unlockedNext;
`ifdef PWD_LOCKOUT_EN
            r_failCount <= w_failCountNext;
            r_lockTimer <= w_lockTimerNext;
`endif
        end
    end

    // Next-state logic. clear beats a same-cycle digit, and a pass beats relock in RESULT.
    always_comb begin
        w_stateNext     = r_state;
        w_indexNext     = r_index;
        w_mismatchNext  = r_mismatch;
        w_countNext     = r_count;
        w_unlockedNext  = r_unlocked;
        pass_pulse      = 1'b0;
        fail_pulse      = 1'b0;
`ifdef PWD_LOCKOUT_EN
        w_failCountNext = r_failCount;
        w_lockTimerNext = r_lockTimer;
`endif

        if (relock) begin
            w_unlockedNext = 1'b0;
        end

        case (r_state)
            IDLE, ENTER: begin
                if (clear) begin
                    w_indexNext    = '0;
                    w_mismatchNext = 1'b0;
                    w_countNext    = '0;
                    w_stateNext    = IDLE;
                end else if (digit_valid && !r_unlocked) begin
                    w_mismatchNext = r_mismatch | (digit_in != mem_data);
                    w_countNext    = r_count + COUNT_ONE;
                    if (r_index == LAST_INDEX) begin
                        w_indexNext = '0;
                        w_stateNext = RESULT;
                    end else begin
                        w_indexNext = r_index + INDEX_ONE;
                        w_stateNext = ENTER;
                    end
                end
            end
            RESULT: begin
                w_mismatchNext = 1'b0;
                w_countNext    = '0;
                w_stateNext    = IDLE;
                if (!r_mismatch) begin
                    pass_pulse     = 1'b1;
                    w_unlockedNext = 1'b1;
`ifdef PWD_LOCKOUT_EN
                    w_failCountNext = '0;
`endif
                end else begin
                    fail_pulse = 1'b1;
`ifdef PWD_LOCKOUT_EN
                    w_failCountNext = r_failCount + FAIL_ONE;
                    if (r_failCount == LAST_FAIL) begin
                        w_stateNext     = LOCKED;
                        w_lockTimerNext = TIMER_LOAD;
                    end
`endif
                end
            end
`ifdef PWD_LOCKOUT_EN
            LOCKED: begin
                if (r_lockTimer == '0) begin
                    w_stateNext     = IDLE;
                    w_failCountNext = '0;
                end else begin
                    w_lockTimerNext = r_lockTimer - TIMER_ONE;
                end
            end
`endif
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    assign mem_address = r_index;
    assign digit_count = r_count;
    assign unlocked    = r_unlocked;
`ifdef PWD_LOCKOUT_EN
    assign locked_out  = (r_state == LOCKED);
`else
    assign locked_out  = 1'b0;
`endif

endmodule

// File: doc/password_checker.md
Name: password_checker

Overview:
- Read-side companion to the password store in the serial password lock.
- Accepts user digits serially, one per `digit_valid` strobe, and drives the store's address port to fetch the matching stored digit.
- Compares each entered digit in the same cycle and accumulates a mismatch flag.
- After the last digit, reports pass/fail and holds the lock open on success.

Parameters:
- DIGITS, 4, password length in digits; also the store depth.
- DIGIT_W, 4, bits per digit; must equal the store data width.
- ADDR_W, $clog2(DIGITS) (2), store address width.
- MAX_FAILS, 3, consecutive failures before lockout (only with PWD_LOCKOUT_EN).
- LOCK_CYCLES, 16, lockout duration in CLK cycles (only with PWD_LOCKOUT_EN).

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RST  in  1  synchronous, active-high reset.
- digit_valid  in  1  entered digit is present on digit_in this cycle.
- digit_in  in  DIGIT_W  entered digit.
- clear  in  1  abandon the current entry.
- relock  in  1  drop the unlocked state.
- mem_address  out  ADDR_W  store read address (= entry index register).
- mem_data  in  DIGIT_W  store read data; combinational from mem_address, same cycle.
- digit_count  out  ADDR_W+1  digits accepted in the current entry.
- pass_pulse  out  1  one-cycle pass strobe.
- fail_pulse  out  1  one-cycle fail strobe.
- unlocked  out  1  level; high after a pass until relock.
- locked_out  out  1  lockout active.

Behaviour:
- Reset: state=IDLE, index=0, mismatch=0, digit_count=0, mem_address=0, pass_pulse=0, fail_pulse=0, unlocked=0, locked_out=0, fail counter=0.
- FSM states: IDLE, ENTER, RESULT (plus LOCKED with the feature).
- Digit acceptance:
  - Condition: digit_valid=1, state is IDLE or ENTER, unlocked=0, locked_out=0.
  - Effect: mismatch <= mismatch | (digit_in != mem_data); index++; digit_count++; IDLE->ENTER.
- Final digit: when the accepted digit has index==DIGITS-1, next state is RESULT; index wraps to 0.
- RESULT (exactly one cycle):
  - Final mismatch=0 -> pass_pulse=1 and unlocked<=1 next edge.
  - Otherwise -> fail_pulse=1.
  - Then mismatch=0, digit_count=0, state->IDLE.
  - digit_valid in RESULT is ignored; the digit is not buffered.
- Latency: last digit accepted at edge N -> pulse high during cycle N+1 -> unlocked high from edge N+2.
- clear:
  - In IDLE/ENTER: index=0, mismatch=0, digit_count=0, state=IDLE.
  - Priority over a simultaneous digit_valid (that digit is dropped).
  - Ignored in RESULT and LOCKED.
- relock:
  - unlocked<=0.
  - If asserted in the RESULT cycle of a pass, the pass wins and unlocked ends 1.
- Digits presented while unlocked=1 are ignored and the index does not advance.
- mem_address is the registered index; it is never X and stays stable between accepted digits.
- The checker never writes the store; it has no write-enable output.

Optional Feature:
- Macro: PWD_LOCKOUT_EN.
- With PWD_LOCKOUT_EN defined:
  - The fail counter increments on each fail_pulse.
  - A pass resets the counter.
  - When the counter reaches MAX_FAILS, RESULT->LOCKED instead of IDLE; locked_out=1 from the next edge.
  - While LOCKED, digits and clear are ignored and a down-counter runs for LOCK_CYCLES cycles.
  - On expiry: state=IDLE, locked_out=0, fail counter=0.
  - RST mid-lockout returns everything to reset values.
- Without the macro:
  - No fail counter or LOCKED state.
  - locked_out is tied 0.
  - Every RESULT returns to IDLE.

Test Plan:
- Store holds 1,2,3,4; enter 1,2,3,4 on consecutive cycles -> mem_address steps 0,1,2,3; pass_pulse one cycle after the 4th digit; unlocked=1 next edge; fail_pulse never asserts.
- Enter 1,2,9,4 -> fail_pulse one cycle after the 4th digit; unlocked stays 0; digit_count returns to 0.
- Enter 1,2, then clear together with digit_valid (digit 3) -> digit_count=0, mem_address=0; a following 1,2,3,4 passes.
- While unlocked=1, present digits -> ignored; assert relock in the RESULT cycle of a fresh pass after a prior relock -> unlocked ends 1.
- RST asserted after 3 digits -> all outputs at reset values next edge; the 4th digit restarts the entry at index 0.
- With PWD_LOCKOUT_EN, MAX_FAILS=3, LOCK_CYCLES=16: three wrong entries -> locked_out=1 for 16 cycles; digits ignored; then IDLE and a correct entry passes.
